config_manager_param_uc: RTL and testbench

Parametrised control unit for the configuration path. Sequences reception of N_CAMPOS configuration fields from the serial receiver and checks parity on each field. Emits a one-hot load strobe per accepted field and an atomic commit pulse once all fields are valid. Adds a per-field inter-byte timeout and an error cause code; sits between the UART receiver and the configuration register bank.

---
 rtl/config_manager_param_uc.sv | 150 +++++++++++++++
 tb/tb_config_manager_param_uc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_manager_param_uc.sv
// Field-sequencing control unit for the configuration path: parity-checked field loads,
// atomic commit, error cause code. Inter-field timeout is built only with CONFIG_TIMEOUT_EN.
module config_manager_param_uc #(
    parameter int N_CAMPOS       = 5,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CICLOS = 50000,
    parameter int TO_W           = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                receber_config,
    input  logic                fim_recepcao_config,
    input  logic                parity_config_ok,
    output logic [N_CAMPOS-1:0] load_campo,
    output logic                commit_config,
    output logic [IDX_W-1:0]    campo_atual,
    output logic                ocupado,
    output logic                pronto_config,
    output logic                erro_config,
    output logic [1:0]          codigo_erro,
    output logic [1:0]          estado
);

    typedef enum logic [1:0] {
        INICIAL    = 2'd0,
        RECEBE     = 2'd1,
        FIM_CONFIG = 2'd2,
        ERRO       = 2'd3
    } estado_t;

    localparam logic [1:0] COD_NENHUM    = 2'b00;
    localparam logic [1:0] COD_PARIDADE  = 2'b01;
    localparam logic [1:0] COD_TIMEOUT   = 2'b10;
    localparam logic [N_CAMPOS-1:0] UM   = N_CAMPOS'(1);
    localparam logic [IDX_W-1:0] ULTIMO  = IDX_W'(N_CAMPOS - 1);

    // Reject parameter sets that cannot index every field or hold the timeout count.
    if (N_CAMPOS < 2 || N_CAMPOS > 16 || (1 << IDX_W) < N_CAMPOS ||
        TIMEOUT_CICLOS < 2 || (64'(1) << TO_W) <= 64'(TIMEOUT_CICLOS)) begin : g_param_check
        $error("config_manager_param_uc: inconsistent parameters");
    end

    estado_t          state_q, state_d;
    logic [IDX_W-1:0] campo_q, campo_d;
    logic [1:0]       codigo_q, codigo_d;
    logic             erro_novo_q, erro_novo_d;  // marks the first cycle spent in ERRO
    logic             expirou;

`ifdef CONFIG_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;

    // Counts idle RECEBE cycles; any accepted or rejected field restarts the count.
    always_comb begin
        to_d = '0;
        if (state_q == RECEBE && !fim_recepcao_config) begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end

    assign expirou = (to_q == TO_W'(TIMEOUT_CICLOS - 1));
`else
    assign expirou = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= INICIAL;
            campo_q     <= '0;
            codigo_q    <= COD_NENHUM;
            erro_novo_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            campo_q     <= campo_d;
            codigo_q    <= codigo_d;
            erro_novo_q <= erro_novo_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        campo_d       = campo_q;
        codigo_d      = codigo_q;
        erro_novo_d   = 1'b0;
        load_campo    = '0;
        commit_config = 1'b0;
        pronto_config = 1'b0;
        ocupado       = 1'b0;
        erro_config   = 1'b0;
        case (state_q)
            INICIAL: begin
                if (receber_config) begin
                    state_d  = RECEBE;
                    campo_d  = '0;
                    codigo_d = COD_NENHUM;
                end
            end
            RECEBE: begin
                ocupado = 1'b1;
                // A field arriving on the expiry cycle takes priority over the timeout.
                if (fim_recepcao_config) begin
                    if (parity_config_ok) begin
                        load_campo = UM << campo_q;
                        if (campo_q == ULTIMO) begin
                            state_d = FIM_CONFIG;
                        end else begin
                            campo_d = campo_q + 1'b1;
                        end
                    end else begin
                        state_d     = ERRO;
                        codigo_d    = COD_PARIDADE;
                        erro_novo_d = 1'b1;
                    end
                end else if (expirou) begin
                    state_d     = ERRO;
                    codigo_d    = COD_TIMEOUT;
                    erro_novo_d = 1'b1;
                end
            end
            FIM_CONFIG: begin
                commit_config = 1'b1;
                pronto_config = 1'b1;
                state_d       = INICIAL;
                campo_d       = '0;
            end
            ERRO: begin
                erro_config   = 1'b1;
                pronto_config = erro_novo_q;
                if (receber_config) begin
                    state_d  = RECEBE;
                    campo_d  = '0;
                    codigo_d = COD_NENHUM;
                end
            end
            default: state_d = INICIAL;
        endcase
    end

    assign campo_atual = campo_q;
    assign codigo_erro = codigo_q;
    assign estado      = state_q;

endmodule

// File: tb/tb_config_manager_param_uc.sv
// Randomised bench for config_manager_param_uc: a 5-field and an 8-field instance, with a
// field-level reference model feeding an expected-event queue checked by negedge monitors.
module tb_config_manager_param_uc;

    localparam int N0 = 5;
    localparam int N1 = 8;
    localparam int T  = 100;
    localparam int W  = 22;
`ifdef CONFIG_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [1:0] receber = '0;
    logic [1:0] fim = '0;
    logic [1:0] par = '0;

    logic [N0-1:0] load0;
    logic [N1-1:0] load1;
    logic [2:0] campo0, campo1;
    logic [1:0] cod0, cod1, est0, est1;
    logic commit0, commit1, ocup0, ocup1, pronto0, pronto1, erro0, erro1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int gap_a[16];
    bit par_a[16];

    config_manager_param_uc #(.N_CAMPOS(N0), .IDX_W(3), .TIMEOUT_CICLOS(T), .TO_W(16)) u_dut0 (
        .clock(clock), .reset(reset), .receber_config(receber[0]),
        .fim_recepcao_config(fim[0]), .parity_config_ok(par[0]),
        .load_campo(load0), .commit_config(commit0), .campo_atual(campo0),
        .ocupado(ocup0), .pronto_config(pronto0), .erro_config(erro0),
        .codigo_erro(cod0), .estado(est0)
    );

    config_manager_param_uc #(.N_CAMPOS(N1), .IDX_W(3), .TIMEOUT_CICLOS(T), .TO_W(16)) u_dut1 (
        .clock(clock), .reset(reset), .receber_config(receber[1]),
        .fim_recepcao_config(fim[1]), .parity_config_ok(par[1]),
        .load_campo(load1), .commit_config(commit1), .campo_atual(campo1),
        .ocupado(ocup1), .pronto_config(pronto1), .erro_config(erro1),
        .codigo_erro(cod1), .estado(est1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [W-1:0] rec_load(input int idx);
        logic [15:0] one;
        logic [3:0] i4;
        one = 16'd1;
        i4 = 4'(idx);
        return {2'd1, i4, one << idx};
    endfunction

    function automatic logic [W-1:0] rec_end(input logic cm, input logic er, input logic [1:0] cd);
        return {2'd2, 4'd0, 12'd0, cm, er, cd};
    endfunction

    task automatic push(input int sel, input logic [W-1:0] r);
        if (sel == 1) exp_q1.push_back(r);
        else exp_q0.push_back(r);
    endtask

    task automatic compare_pop(input int sel, input string name, input logic [W-1:0] got);
        logic [W-1:0] want;
        int sz;
        sz = (sel == 1) ? exp_q1.size() : exp_q0.size();
        checks++;
        if (sz == 0) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h with no event expected at %0t", name, sel, got, $time);
        end else begin
            want = (sel == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, sel, got, want, $time);
            end
        end
    endtask

    task automatic observe(input int sel, input logic [15:0] ld, input logic [3:0] idx,
                           input logic cm, input logic pr, input logic er, input logic [1:0] cd);
        if (ld != 16'd0) compare_pop(sel, "load", {2'd1, idx, ld});
        if (pr) compare_pop(sel, "frame_end", rec_end(cm, er, cd));
        if (cm) begin
            checks++;
            if (!pr) begin
                errors++;
                $display("FAIL commit_without_pronto dut%0d: got commit=1 pronto=0 at %0t", sel, $time);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset) observe(0, 16'(load0), 4'(campo0), commit0, pronto0, erro0, cod0);
    end

    always @(negedge clock) begin
        if (reset) observe(1, 16'(load1), 4'(campo1), commit1, pronto1, erro1, cod1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: fields are accepted in order until the first one whose idle gap reaches
    // T (timeout) or whose parity is bad; only a complete frame commits.
    task automatic run_frame(input int sel, input int n);
        int err_at;
        int g;
        logic [1:0] code;
        bit to_hit;
        err_at = n;
        code = 2'b00;
        for (int i = 0; i < n; i++) begin
            if (TO_ON && gap_a[i] >= T) begin code = 2'b10; err_at = i; break; end
            if (!par_a[i]) begin code = 2'b01; err_at = i; break; end
            push(sel, rec_load(i));
        end
        if (err_at == n) push(sel, rec_end(1'b1, 1'b0, 2'b00));
        else push(sel, rec_end(1'b0, 1'b1, code));

        receber[sel] = 1'b1;
        tick();
        receber[sel] = 1'b0;
        for (int i = 0; i < n; i++) begin
            to_hit = TO_ON && gap_a[i] >= T;
            g = to_hit ? T + 2 : gap_a[i];
            for (int c = 0; c < g; c++) begin
                if (c == 0 && $urandom_range(0, 3) == 0) receber[sel] = 1'b1;
                tick();
                receber[sel] = 1'b0;
            end
            if (to_hit) break;
            chk("ocupado_at_field", 32'((sel == 1) ? ocup1 : ocup0), 32'd1);
            fim[sel] = 1'b1;
            par[sel] = par_a[i];
            tick();
            fim[sel] = 1'b0;
            par[sel] = 1'($urandom_range(0, 1));
            if (!par_a[i]) break;
        end
        repeat (3) tick();
        chk("erro_level", 32'((sel == 1) ? erro1 : erro0), 32'(err_at != n));
        chk("codigo_held", 32'((sel == 1) ? cod1 : cod0), 32'(code));
        for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
            fim[sel] = 1'b1;
            par[sel] = 1'b1;
            tick();
            fim[sel] = 1'b0;
            tick();
        end
    endtask

    task automatic fill(input int n, input int gap);
        for (int i = 0; i < 16; i++) begin
            gap_a[i] = gap;
            par_a[i] = (i < n);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            gap_a[i] = $urandom_range(0, 12);
            if ($urandom_range(0, 9) == 0) gap_a[i] = T - 2 + $urandom_range(0, 3);
            par_a[i] = ($urandom_range(0, 9) != 0);
        end
    endtask

    task automatic reset_mid_frame();
        push(0, rec_load(0));
        push(0, rec_load(1));
        receber[0] = 1'b1;
        tick();
        receber[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            repeat (3) tick();
            fim[0] = 1'b1;
            par[0] = 1'b1;
            tick();
            fim[0] = 1'b0;
        end
        tick();
        fim[0] = 1'b1;
        par[0] = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_load", 32'(load0), 32'd0);
        chk("rst_ocupado", 32'(ocup0), 32'd0);
        chk("rst_campo", 32'(campo0), 32'd0);
        chk("rst_commit", 32'(commit0), 32'd0);
        chk("rst_pronto", 32'(pronto0), 32'd0);
        chk("rst_estado", 32'(est0), 32'd0);
        tick();
        fim[0] = 1'b0;
        tick();
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            fim[0] = 1'b1;
            tick();
            fim[0] = 1'b0;
            tick();
        end
        chk("rst_no_pending_events", 32'(exp_q0.size()), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("por_load0", 32'(load0), 32'd0);
        chk("por_load1", 32'(load1), 32'd0);
        chk("por_campo0", 32'(campo0), 32'd0);
        chk("por_codigo0", 32'(cod0), 32'd0);
        chk("por_ocupado0", 32'(ocup0), 32'd0);
        chk("por_flags0", 32'({commit0, pronto0, erro0}), 32'd0);
        reset = 1'b1;
        tick();

        fill(N0, 9);
        run_frame(0, N0);
        fill(N0, 4);
        par_a[2] = 1'b0;
        run_frame(0, N0);
        fill(N0, 2);
        run_frame(0, N0);
`ifdef CONFIG_TIMEOUT_EN
        fill(N0, 3);
        gap_a[2] = T;
        run_frame(0, N0);
        fill(N0, 3);
        gap_a[2] = T - 1;
        run_frame(0, N0);
        fill(N0, 1);
        gap_a[0] = T + 40;
        run_frame(0, N0);
`else
        fill(N0, 3);
        gap_a[2] = 10000;
        run_frame(0, N0);
`endif
        reset_mid_frame();
        for (int f = 0; f < 30; f++) begin
            fill_random(N0);
            run_frame(0, N0);
        end

        fill(N1, 0);
        run_frame(1, N1);
        for (int f = 0; f < 6; f++) begin
            fill_random(N1);
            run_frame(1, N1);
        end

        repeat (5) tick();
        chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
        chk("queue1_drained", 32'(exp_q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
